id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Registers decoded instruction fields from decode.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB registers, and selects sources.
- Drives OP_A, OP_B and ALU_FUN straight into the ALU.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and flush.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- ID_VALID  in  1  decode presents a valid instruction.
- ID_PC  in  XLEN  instruction PC.
- ID_RS1_DATA  in  XLEN  regfile read data, rs1.
- ID_RS2_DATA  in  XLEN  regfile read data, rs2.
- ID_IMM  in  XLEN  sign-extended immediate.
- ID_RS1_ADDR  in  RADDR_W  rs1 index.
- ID_RS2_ADDR  in  RADDR_W  rs2 index.
- ID_RD_ADDR  in  RADDR_W  rd index.
- ID_USES_RS1  in  1  instruction reads rs1.
- ID_USES_RS2  in  1  instruction reads rs2.
- ID_ALU_FUN  in  4  ALU function code.
- ID_SRCA_SEL  in  2  0 = rs1, 1 = PC, 2 = zero.
- ID_SRCB_SEL  in  2  0 = rs2, 1 = IMM, 2 = constant 4.
- ID_REG_WRITE  in  1  writes rd.
- ID_MEM_READ  in  1  instruction is a load.
- MEM_RD_ADDR  in  RADDR_W  EX/MEM destination.
- MEM_REG_WRITE  in  1  EX/MEM writes rd.
- MEM_RESULT  in  XLEN  EX/MEM ALU result.
- WB_RD_ADDR  in  RADDR_W  MEM/WB destination.
- WB_REG_WRITE  in  1  MEM/WB writes rd.
- WB_DATA  in  XLEN  MEM/WB writeback data.
- STALL_IN  in  1  downstream stall; hold this stage.
- FLUSH  in  1  branch or jump redirect; kill this stage.
- ID_STALL  out  1  decode must hold its current instruction.
- EX_VALID  out  1  stage holds a live instruction.
- OP_A  out  XLEN  ALU operand A.
- OP_B  out  XLEN  ALU operand B.
- ALU_FUN  out  4  ALU function code.
- EX_RS2_FWD  out  XLEN  forwarded rs2, used as store data.
- EX_RD_ADDR  out  RADDR_W  registered rd.
- EX_REG_WRITE  out  1  rd write enable, gated by EX_VALID.
- EX_MEM_READ  out  1  load flag, gated by EX_VALID.

Behaviour:
- Timing: one clock CLK, rising edge. Reset is synchronous, active-low, on RST_N.
- Reset: all stage registers clear to 0. This gives EX_VALID=0, ALU_FUN=4'b0000 (ADD), OP_A=0, OP_B=0, EX_RS2_FWD=0, EX_RD_ADDR=0, EX_REG_WRITE=0, EX_MEM_READ=0 and ID_STALL=0.
- Registered fields: PC, RS1/RS2 data and addresses, IMM, RD, ALU_FUN, SRCA/SRCB_SEL, REG_WRITE, MEM_READ, USES_RS1/RS2 and VALID.
- Forwarding is combinational from the registered fields.
  - Per operand: if MEM_REG_WRITE, MEM_RD_ADDR != 0 and MEM_RD_ADDR == rsN, use MEM_RESULT.
  - Else if the same conditions hold for WB_*, use WB_DATA.
  - Else use the registered rsN data.
  - MEM has priority over WB. x0 is never forwarded.
- OP_A mux: SRCA_SEL 0 → forwarded rs1, 1 → PC, 2 → 0, 3 → 0.
- OP_B mux: SRCB_SEL 0 → forwarded rs2, 1 → IMM, 2 → 32'd4, 3 → 0.
- EX_RS2_FWD always carries the forwarded rs2, independent of SRCB_SEL.
- Load-use hazard, combinational: EX_VALID & EX_MEM_READ & EX_RD_ADDR != 0 & ID_VALID, and (ID_USES_RS1 & ID_RS1_ADDR == EX_RD_ADDR, or ID_USES_RS2 & ID_RS2_ADDR == EX_RD_ADDR).
- ID_STALL = STALL_IN | (load_use & ~FLUSH).
- Register update priority, per cycle:
  - ~RST_N: clear.
  - FLUSH: EX_VALID <= 0, other fields don't-care (cleared). FLUSH beats STALL_IN.
  - STALL_IN: hold all fields. The RS1/RS2 data registers reload with their current forwarded values, so a WB retiring during the stall is not lost.
  - load_use: bubble, EX_VALID <= 0. Decode holds, so the consumer re-enters next cycle and receives load data via WB forwarding.
  - Otherwise: load the ID_* fields, with EX_VALID <= ID_VALID.
- Latency: one cycle from ID capture to ALU operands. Load-use costs exactly one bubble.
- Bubble/invalid outputs: EX_REG_WRITE and EX_MEM_READ read 0 whenever EX_VALID=0. OP_A, OP_B and ALU_FUN keep their cleared or held values.
- Back-to-back: a new instruction is accepted every cycle when there is no hazard or stall.

Decomposition:
- Shared package ex_pkg:
  - alu_fun_t enum: ADD 0000, SUB 1000, OR 0110, AND 0111, XOR 0100, SRL 0101, SLL 0001, SRA 1101, SLT 0010, SLTU 0011, LUI 1001.
  - srca_sel_t and srcb_sel_t enums.
  - XLEN constant.
- Sub-module fwd_mux: rs address, registered data, MEM/WB triples in, forwarded value out. Instantiated twice, for rs1 and rs2.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with ID_VALID=1 → EX_VALID=0, OP_A=0, OP_B=0, ALU_FUN=0000, ID_STALL=0.
- MEM forward: EX captures rs1=x5 (regfile data 0x11) with SRCA_SEL=0, while MEM_RD_ADDR=5, MEM_REG_WRITE=1, MEM_RESULT=0x1000_0000, and WB also targets x5 with 0x22 → OP_A=0x1000_0000 (MEM priority). Repeat with rd=0 → OP_A=0x11.
- Load-use: EX holds a load to x7; ID instruction uses rs2=x7 → ID_STALL=1 for one cycle and EX_VALID=0 next cycle. The following cycle WB_DATA=0xF0F0_F0F0 targets x7 → OP_B=0xF0F0_F0F0.
- Stall capture: STALL_IN=1 for 3 cycles while WB writes x3=0xABCD in cycle 1 only, EX rs1=x3 → OP_A=0xABCD in cycles 1–3 and after release.
- Flush vs stall: FLUSH=1 and STALL_IN=1 in the same cycle → EX_VALID=0 next cycle and EX_REG_WRITE=0.
- Source select: SRCA=PC with PC=0x100, SRCB=4, ALU_FUN=ADD → OP_A=0x100, OP_B=4. Also SRCB=IMM with IMM=0xFFFF_F000, ALU_FUN=LUI → OP_B=0xFFFF_F000, ALU_FUN=1001.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types for the ID/EX stage: ALU function codes, operand-source
// selects and the default datapath width.
package ex_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SLL  = 4'b0001,
    ALU_SRA  = 4'b1101,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_LUI  = 4'b1001
  } alu_fun_t;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_PC   = 2'd1,
    SRCA_ZERO = 2'd2,
    SRCA_RSVD = 2'd3
  } srca_sel_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2,
    SRCB_RSVD = 2'd3
  } srcb_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass: picks EX/MEM result, then MEM/WB data, then the registered
// regfile value. x0 never matches so it always reads its registered value.
module fwd_mux
  import ex_pkg::*;
#(
  parameter int XLEN    = ex_pkg::XLEN,
  parameter int RADDR_W = ex_pkg::RADDR_W
) (
  input  logic [RADDR_W-1:0] rs_addr_i,
  input  logic [XLEN-1:0]    rs_data_i,
  input  logic [RADDR_W-1:0] mem_rd_addr_i,
  input  logic               mem_reg_write_i,
  input  logic [XLEN-1:0]    mem_result_i,
  input  logic [RADDR_W-1:0] wb_rd_addr_i,
  input  logic               wb_reg_write_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic [XLEN-1:0]    fwd_data_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write_i && (mem_rd_addr_i != '0) && (mem_rd_addr_i == rs_addr_i);
  assign wb_hit  = wb_reg_write_i  && (wb_rd_addr_i  != '0) && (wb_rd_addr_i  == rs_addr_i);

  always_comb begin
    fwd_data_o = rs_data_i;
    if (mem_hit) begin
      fwd_data_o = mem_result_i;
    end else if (wb_hit) begin
      fwd_data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand bypass, source selection,
// load-use bubble insertion, downstream stall and flush handling.
module id_ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN    = ex_pkg::XLEN,
  parameter int RADDR_W = ex_pkg::RADDR_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ID_VALID,
  input  logic [XLEN-1:0]    ID_PC,
  input  logic [XLEN-1:0]    ID_RS1_DATA,
  input  logic [XLEN-1:0]    ID_RS2_DATA,
  input  logic [XLEN-1:0]    ID_IMM,
  input  logic [RADDR_W-1:0] ID_RS1_ADDR,
  input  logic [RADDR_W-1:0] ID_RS2_ADDR,
  input  logic [RADDR_W-1:0] ID_RD_ADDR,
  input  logic               ID_USES_RS1,
  input  logic               ID_USES_RS2,
  input  logic [3:0]         ID_ALU_FUN,
  input  logic [1:0]         ID_SRCA_SEL,
  input  logic [1:0]         ID_SRCB_SEL,
  input  logic               ID_REG_WRITE,
  input  logic               ID_MEM_READ,
  input  logic [RADDR_W-1:0] MEM_RD_ADDR,
  input  logic               MEM_REG_WRITE,
  input  logic [XLEN-1:0]    MEM_RESULT,
  input  logic [RADDR_W-1:0] WB_RD_ADDR,
  input  logic               WB_REG_WRITE,
  input  logic [XLEN-1:0]    WB_DATA,
  input  logic               STALL_IN,
  input  logic               FLUSH,
  output logic               ID_STALL,
  output logic               EX_VALID,
  output logic [XLEN-1:0]    OP_A,
  output logic [XLEN-1:0]    OP_B,
  output logic [3:0]         ALU_FUN,
  output logic [XLEN-1:0]    EX_RS2_FWD,
  output logic [RADDR_W-1:0] EX_RD_ADDR,
  output logic               EX_REG_WRITE,
  output logic               EX_MEM_READ
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [RADDR_W-1:0] rd_addr;
    alu_fun_t           alu_fun;
    srca_sel_t          srca_sel;
    srcb_sel_t          srcb_sel;
    logic               reg_write;
    logic               mem_read;
  } stage_t;

  stage_t          stage_q, stage_d;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            load_use;

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .rs_addr_i      (stage_q.rs1_addr),
    .rs_data_i      (stage_q.rs1_data),
    .mem_rd_addr_i  (MEM_RD_ADDR),
    .mem_reg_write_i(MEM_REG_WRITE),
    .mem_result_i   (MEM_RESULT),
    .wb_rd_addr_i   (WB_RD_ADDR),
    .wb_reg_write_i (WB_REG_WRITE),
    .wb_data_i      (WB_DATA),
    .fwd_data_o     (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .rs_addr_i      (stage_q.rs2_addr),
    .rs_data_i      (stage_q.rs2_data),
    .mem_rd_addr_i  (MEM_RD_ADDR),
    .mem_reg_write_i(MEM_REG_WRITE),
    .mem_result_i   (MEM_RESULT),
    .wb_rd_addr_i   (WB_RD_ADDR),
    .wb_reg_write_i (WB_REG_WRITE),
    .wb_data_i      (WB_DATA),
    .fwd_data_o     (rs2_fwd)
  );

  assign load_use = stage_q.valid && stage_q.mem_read && (stage_q.rd_addr != '0) && ID_VALID &&
                    ((ID_USES_RS1 && (ID_RS1_ADDR == stage_q.rd_addr)) ||
                     (ID_USES_RS2 && (ID_RS2_ADDR == stage_q.rd_addr)));

  assign ID_STALL = STALL_IN | (load_use & ~FLUSH);

  // During a stall the operand data registers track the bypass so a WB
  // retiring mid-stall is still seen once the stall releases.
  always_comb begin
    stage_d = stage_q;
    if (FLUSH) begin
      stage_d = '0;
    end else if (STALL_IN) begin
      stage_d.rs1_data = rs1_fwd;
      stage_d.rs2_data = rs2_fwd;
    end else if (load_use) begin
      stage_d.valid = 1'b0;
    end else begin
      stage_d.valid     = ID_VALID;
      stage_d.pc        = ID_PC;
      stage_d.rs1_data  = ID_RS1_DATA;
      stage_d.rs2_data  = ID_RS2_DATA;
      stage_d.imm       = ID_IMM;
      stage_d.rs1_addr  = ID_RS1_ADDR;
      stage_d.rs2_addr  = ID_RS2_ADDR;
      stage_d.rd_addr   = ID_RD_ADDR;
      stage_d.alu_fun   = alu_fun_t'(ID_ALU_FUN);
      stage_d.srca_sel  = srca_sel_t'(ID_SRCA_SEL);
      stage_d.srcb_sel  = srcb_sel_t'(ID_SRCB_SEL);
      stage_d.reg_write = ID_REG_WRITE;
      stage_d.mem_read  = ID_MEM_READ;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    OP_A = '0;
    case (stage_q.srca_sel)
      SRCA_RS1: OP_A = rs1_fwd;
      SRCA_PC:  OP_A = stage_q.pc;
      default:  OP_A = '0;
    endcase
  end

  always_comb begin
    OP_B = '0;
    case (stage_q.srcb_sel)
      SRCB_RS2:  OP_B = rs2_fwd;
      SRCB_IMM:  OP_B = stage_q.imm;
      SRCB_FOUR: OP_B = XLEN'(4);
      default:   OP_B = '0;
    endcase
  end

  assign ALU_FUN      = stage_q.alu_fun;
  assign EX_VALID     = stage_q.valid;
  assign EX_RS2_FWD   = rs2_fwd;
  assign EX_RD_ADDR   = stage_q.rd_addr;
  assign EX_REG_WRITE = stage_q.valid & stage_q.reg_write;
  assign EX_MEM_READ  = stage_q.valid & stage_q.mem_read;

endmodule
